// File: rtl/fp32_pkg.sv
// Shared FP32 definitions: field widths, canonical NaN, unpacked operand view.
// Used by the multiplier and the adder in the PE multiply-accumulate path.
package fp32_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  localparam logic [31:0] FP32_QNAN = 32'h7FC00000;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
    logic             is_zero;
    logic             is_inf;
    logic             is_nan;
  } fp32_unpacked_t;

  typedef enum logic [1:0] {
    SP_NONE,
    SP_NAN,
    SP_INF,
    SP_ZERO
  } fp32_special_e;

  // Subnormals are classified as zero (flush-to-zero on input).
  function automatic fp32_unpacked_t fp32_unpack(input logic [31:0] x);
    fp32_unpacked_t u;
    u.sign    = x[31];
    u.exp     = x[30:23];
    u.man     = x[22:0];
    u.is_zero = (u.exp == '0);
    u.is_inf  = (u.exp == '1) && (u.man == '0);
    u.is_nan  = (u.exp == '1) && (u.man != '0);
    return u;
  endfunction

endpackage

// File: rtl/fp32_round_pack.sv
// Round-to-nearest-even, overflow/underflow saturation and packing of a
// normalized FP32 value. Purely combinational.
module fp32_round_pack
  import fp32_pkg::*;
(
  input  logic                    sign,
  input  logic signed [9:0]       exp,
  input  logic [MAN_W-1:0]        man,
  input  logic                    guard,
  input  logic                    sticky,
  output logic [31:0]             result
);

  logic               inc;
  logic [MAN_W:0]     man_sum;
  logic signed [10:0] exp_fin;

  always_comb begin
    inc     = guard & (sticky | man[0]);
    // A carry out of the mantissa leaves man_sum[MAN_W-1:0] at zero and bumps the exponent.
    man_sum = {1'b0, man} + {{MAN_W{1'b0}}, inc};
    exp_fin = $signed({exp[9], exp}) + $signed({10'b0, man_sum[MAN_W]});
    if (exp_fin >= 11'sd255) begin
      result = {sign, 8'hFF, 23'h0};
    end else if (exp_fin <= 11'sd0) begin
      result = {sign, 31'h0};
    end else begin
      result = {sign, exp_fin[7:0], man_sum[MAN_W-1:0]};
    end
  end

endmodule

// File: rtl/fp32_multiplier.sv
// Two-stage pipelined FP32 multiplier (RNE, FTZ). A transfer happens on a rising
// edge when valid && ready on that side; in_ready is combinational from out_ready.
module fp32_multiplier
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] result,
  output logic        out_valid,
  input  logic        out_ready
);

  fp32_unpacked_t    ua, ub;
  fp32_special_e     special_c;
  logic signed [9:0] exp_sum_c;
  logic [47:0]       prod_c;

  logic              s1_valid;
  logic              s1_sign;
  logic signed [9:0] s1_exp;
  logic [47:0]       s1_prod;
  fp32_special_e     s1_special;

  logic              s1_load, s2_load;
  logic [MAN_W-1:0]  norm_man;
  logic              norm_guard, norm_sticky;
  logic signed [9:0] norm_exp;
  logic [31:0]       rounded;
  logic [31:0]       s2_value;

  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;

  always_comb begin
    ua        = fp32_unpack(a);
    ub        = fp32_unpack(b);
    exp_sum_c = $signed({2'b00, ua.exp}) + $signed({2'b00, ub.exp}) - 10'sd127;
    prod_c    = 48'({1'b1, ua.man}) * 48'({1'b1, ub.man});
    if (ua.is_nan || ub.is_nan || (ua.is_inf && ub.is_zero) || (ua.is_zero && ub.is_inf)) begin
      special_c = SP_NAN;
    end else if (ua.is_inf || ub.is_inf) begin
      special_c = SP_INF;
    end else if (ua.is_zero || ub.is_zero) begin
      special_c = SP_ZERO;
    end else begin
      special_c = SP_NONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_sign    <= 1'b0;
      s1_exp     <= '0;
      s1_prod    <= '0;
      s1_special <= SP_NONE;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign    <= ua.sign ^ ub.sign;
        s1_exp     <= exp_sum_c;
        s1_prod    <= prod_c;
        s1_special <= special_c;
      end
    end
  end

  // Product of two [1,2) significands lies in [1,4): at most one shift right.
  always_comb begin
    if (s1_prod[47]) begin
      norm_man    = s1_prod[46:24];
      norm_guard  = s1_prod[23];
      norm_sticky = |s1_prod[22:0];
      norm_exp    = s1_exp + 10'sd1;
    end else begin
      norm_man    = s1_prod[45:23];
      norm_guard  = s1_prod[22];
      norm_sticky = |s1_prod[21:0];
      norm_exp    = s1_exp;
    end
  end

  fp32_round_pack u_round_pack (
    .sign   (s1_sign),
    .exp    (norm_exp),
    .man    (norm_man),
    .guard  (norm_guard),
    .sticky (norm_sticky),
    .result (rounded)
  );

  always_comb begin
    case (s1_special)
      SP_NAN:  s2_value = FP32_QNAN;
      SP_INF:  s2_value = {s1_sign, 8'hFF, 23'h0};
      SP_ZERO: s2_value = {s1_sign, 31'h0};
      default: s2_value = rounded;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= 32'h0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        result <= s2_value;
      end
    end
  end

endmodule

// File: tb/tb_fp32_multiplier.sv
// Directed-vector bench for fp32_multiplier: hand-computed products, stall and
// reset scenarios, with an in-order expected-result queue.
module tb_fp32_multiplier;

  logic        clk;
  logic        rst_n;
  logic [31:0] a, b;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] result;
  logic        out_valid;
  logic        out_ready;

  logic [31:0] exp_q[$];
  logic [31:0] cur_exp;
  int          n_checks;
  int          n_bad;
  int          hold_cnt;
  bit          block_out;
  bit          stall_chk;
  bit          last_in_fire;

  fp32_multiplier dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .result    (result),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h want %08h", tag, obs, exp);
    end
  endtask

  // One cycle: drive out_ready, sample just before the rising edge, end at the next falling edge.
  task automatic tick();
    out_ready = !block_out && (hold_cnt == 0);
    if (hold_cnt > 0) hold_cnt--;
    #2;
    if (stall_chk && !out_ready) begin
      check_eq("stall_in_ready", 32'(in_ready), 32'd0);
      check_eq("stall_out_valid", 32'(out_valid), 32'd1);
      check_eq("stall_buffered", 32'(exp_q.size()), 32'd2);
      if (exp_q.size() > 0) check_eq("stall_result", result, exp_q[0]);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check_eq("extra_out", 32'(exp_q.size()), 32'd1);
      else check_eq("result", result, exp_q.pop_front());
    end
    last_in_fire = in_valid && in_ready;
    if (last_in_fire) exp_q.push_back(cur_exp);
    @(negedge clk);
  endtask

  // Present a pair and keep in_valid high until it is accepted; in_valid is left high.
  task automatic send(input logic [31:0] va, input logic [31:0] vb, input logic [31:0] ve);
    bit done;
    done     = 1'b0;
    a        = va;
    b        = vb;
    cur_exp  = ve;
    in_valid = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      tick();
      if (last_in_fire) done = 1'b1;
    end
    if (!done) check_eq("send_timeout", 32'(done), 32'd1);
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int n = 0; n < 60 && exp_q.size() > 0; n++) tick();
    if (exp_q.size() > 0) check_eq("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (3) tick();
  endtask

  logic [31:0] vec_a[13] = '{32'hBF800000, 32'h7F800000, 32'h7FC00000, 32'hFF800000,
                             32'h80000000, 32'h7F000000, 32'h00800000, 32'h00400000,
                             32'h3F800001, 32'h3FFFFFFF, 32'hC0000000, 32'h00000000,
                             32'h80800000};
  logic [31:0] vec_b[13] = '{32'h3F800000, 32'h00000000, 32'h3F800000, 32'h3F800000,
                             32'h3F800000, 32'h40000000, 32'h3F000000, 32'h4B000000,
                             32'h3F800001, 32'h3FFFFFFF, 32'h40800000, 32'hFF800000,
                             32'h3F000000};
  logic [31:0] vec_e[13] = '{32'hBF800000, 32'h7FC00000, 32'h7FC00000, 32'hFF800000,
                             32'h80000000, 32'h7F800000, 32'h00000000, 32'h00000000,
                             32'h3F800002, 32'h407FFFFE, 32'hC1000000, 32'h7FC00000,
                             32'h80000000};

  logic [31:0] str_a[6] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                            32'hBFC00000, 32'h3F000000, 32'h40A00000};
  logic [31:0] str_b[6] = '{32'h40000000, 32'h40000000, 32'h40400000,
                            32'h40000000, 32'h3F000000, 32'h40000000};
  logic [31:0] str_e[6] = '{32'h40000000, 32'h40800000, 32'h41100000,
                            32'hC0400000, 32'h3E800000, 32'h41200000};

  initial begin
    n_checks  = 0;
    n_bad     = 0;
    hold_cnt  = 0;
    block_out = 1'b0;
    stall_chk = 1'b0;
    rst_n     = 1'b0;
    a         = '0;
    b         = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cur_exp   = '0;

    // reset values
    repeat (2) @(negedge clk);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_result", result, 32'h0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);

    // basic product with latency check
    send(32'h3FC00000, 32'h40000000, 32'h40400000);
    in_valid = 1'b0;
    check_eq("lat_not_yet", 32'(out_valid), 32'd0);
    tick();
    check_eq("lat_out_valid", 32'(out_valid), 32'd1);
    check_eq("lat_result", result, 32'h40400000);
    drain();

    // directed vectors, back to back
    for (int i = 0; i < 13; i++) send(vec_a[i], vec_b[i], vec_e[i]);
    drain();

    // streaming with a 3-cycle output stall after two pairs are buffered
    send(str_a[0], str_b[0], str_e[0]);
    send(str_a[1], str_b[1], str_e[1]);
    hold_cnt  = 3;
    stall_chk = 1'b1;
    send(str_a[2], str_b[2], str_e[2]);
    stall_chk = 1'b0;
    for (int i = 3; i < 6; i++) send(str_a[i], str_b[i], str_e[i]);
    drain();

    // asynchronous reset with both stages full
    block_out = 1'b1;
    send(32'h40000000, 32'h40400000, 32'h40C00000);
    send(32'h40800000, 32'h40800000, 32'h41800000);
    in_valid = 1'b0;
    check_eq("full_in_ready", 32'(in_ready), 32'd0);
    check_eq("full_out_valid", 32'(out_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("async_rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("async_rst_result", result, 32'h0);
    exp_q.delete();
    block_out = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(32'h40400000, 32'h40400000, 32'h41100000);
    drain();

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
